img_sprite_fetch: RTL and testbench
===================================

# img_sprite_fetch

Pipelined pixel fetcher between the VGA scan counters and an externally instantiated image ROM core, succeeding the fixed 280-wide single-image lookup. Takes a screen coordinate, maps it into a sprite placed at a run-time origin, and supports optional horizontal mirroring and multi-frame animation strips. Drives the ROM address, tracks the ROM read latency, and returns a colour with valid and hit flags. Used by every screen (menu, about, map) that draws bitmap content.

## Interface
- IMG_W, 280, sprite width in pixels
- IMG_H, 40, sprite height in pixels
- FRAMES, 1, frames stored back-to-back in ROM, frame f at base f*IMG_W*IMG_H
- X_W, 10, screen x width
- Y_W, 9, screen y width
- ADDR_W, 17, ROM address width; must hold FRAMES*IMG_W*IMG_H-1
- CLR_W, 12, colour width (RGB444)
- ROM_LAT, 1, ROM read latency in cycles, 1..4
- BG_CLR, 12'h000, colour returned for misses
- KEY_CLR, 12'hF0F, transparent key colour (used only with IMG_KEY_EN)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  coordinate valid this cycle
- x  in  X_W  screen x
- y  in  Y_W  screen y
- org_x  in  X_W  sprite left edge on screen
- org_y  in  Y_W  sprite top edge on screen
- hflip  in  1  mirror horizontally
- frame  in  $clog2(FRAMES)+1  animation frame index
- rom_addr  out  ADDR_W  address to ROM core
- rom_dout  in  CLR_W  ROM data, valid ROM_LAT cycles after rom_addr
- out_valid  out  1  clr/hit valid
- clr  out  CLR_W  pixel colour
- hit  out  1  pixel lies inside sprite (and is opaque with IMG_KEY_EN)

## Operation
- Stage 1 (register): rx = x - org_x, ry = y - org_y computed one bit wider, signed; inside = rx,ry >= 0 and rx < IMG_W and ry < IMG_H and frame < FRAMES. hflip, frame, in_valid captured with them.
- Stage 2 (register): cx = hflip ? IMG_W-1-rx : rx; rom_addr = frame*IMG_W*IMG_H + IMG_W*ry + cx, truncated to ADDR_W. When not inside, rom_addr = 0 (never an out-of-range ROM address).
- Delay line of ROM_LAT stages carries valid and inside alongside the ROM read.
- Output stage (register): out_valid = delayed valid; if inside, clr = rom_dout, hit = 1; else clr = BG_CLR, hit = 0. When delayed valid is 0, clr and hit hold previous values.
- No backpressure; one coordinate accepted per cycle, fully pipelined, no bubbles.
- org_x, org_y, hflip, frame sampled per pixel with x,y; changing them mid-frame affects only subsequent pixels.

## Timing
- Latency from in_valid to out_valid: 3 + ROM_LAT cycles (4 at default).
- rom_addr updates 2 cycles after sampled input; rom_addr changes only on valid pipeline entries.
- Reset (asynchronous assert, synchronous release): rom_addr = 0, out_valid = 0, clr = 0, hit = 0, all pipeline valid bits 0. Reset mid-stream discards all in-flight pixels; first out_valid after release is 3+ROM_LAT cycles after first in_valid.
- Boundaries: rx = IMG_W-1 / ry = IMG_H-1 are inside; rx = IMG_W, ry = IMG_H, or negative offset (x < org_x) are misses. Subtraction wrap-around never aliases into inside.

## Configuration
- IMG_KEY_EN defined: after ROM read, inside pixels whose rom_dout equals KEY_CLR report hit = 0, clr = BG_CLR (transparent sprite). Adds no latency.
- IMG_KEY_EN undefined: KEY_CLR ignored; every inside pixel reports hit = 1, clr = rom_dout.

## Test plan
- Reset: hold rst_n low with in_valid toggling -> out_valid, hit, clr, rom_addr all 0; release, single pixel -> out_valid exactly 4 cycles later (ROM_LAT=1).
- Addressing: org=(0,0), (x,y)=(279,39), frame 0 -> rom_addr = 11199, hit=1, clr = ROM word 11199; (x,y)=(5,2) -> rom_addr 565.
- Bounds: org=(100,50), (x,y)=(99,50), (380,50), (100,90), (0,0) -> hit=0, clr=BG_CLR, rom_addr=0; (100,50) -> rom_addr 0, hit=1.
- Flip and frames: FRAMES=4, org=(0,0), hflip=1, frame=2, (x,y)=(0,1) -> rom_addr = 22400+280+279 = 22959; frame=4 -> miss.
- Streaming and reset mid-flight: 640 back-to-back pixels, ROM_LAT=3 -> 640 consecutive out_valid beats in order with 6-cycle latency; assert rst_n low at beat 300 -> no further out_valid until new input.
- IMG_KEY_EN: ROM word = 12'hF0F inside sprite -> hit=0, clr=BG_CLR; without macro same pixel -> hit=1, clr=12'hF0F.

Source files
------------

// File: rtl/img_sprite_fetch.sv
// img_sprite_fetch: pipelined sprite pixel fetcher in front of an image ROM.
// Define IMG_KEY_EN to treat KEY_CLR pixels as transparent.
module img_sprite_fetch #(
  parameter int IMG_W = 280,
  parameter int IMG_H = 40,
  parameter int FRAMES = 1,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int ADDR_W = 17,
  parameter int CLR_W = 12,
  parameter int ROM_LAT = 1,
  parameter logic [CLR_W-1:0] BG_CLR = 12'h000,
  parameter logic [CLR_W-1:0] KEY_CLR = 12'hF0F
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [X_W-1:0]          x,
  input  logic [Y_W-1:0]          y,
  input  logic [X_W-1:0]          org_x,
  input  logic [Y_W-1:0]          org_y,
  input  logic                    hflip,
  input  logic [$clog2(FRAMES):0] frame,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [CLR_W-1:0]        rom_dout,
  output logic                    out_valid,
  output logic [CLR_W-1:0]        clr,
  output logic                    hit
);
  localparam int F_W = $clog2(FRAMES) + 1;
  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
`ifdef IMG_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  localparam logic [31:0] FSZ = 32'(IMG_W * IMG_H);
  localparam logic [31:0] WSZ = 32'(IMG_W);
  localparam logic [X_W-1:0] W_M1 = X_W'(IMG_W - 1);
  logic [X_W:0] rx;
  logic [Y_W:0] ry;
  logic in_c;
  logic s1_v, s1_in, s1_hf;
  logic [X_W-1:0] s1_x, cx;
  logic [Y_W-1:0] s1_y;
  logic [F_W-1:0] s1_f;
  logic [ADDR_W-1:0] addr_c;
  logic s2_v, s2_in;
  logic [ROM_LAT-1:0] dv, di;
  logic opq;
  // One extra bit keeps negative offsets far above IMG_W/IMG_H, so a single unsigned compare rejects them
  always_comb begin
    rx = {1'b0, x} - {1'b0, org_x};
    ry = {1'b0, y} - {1'b0, org_y};
    in_c = rx < XW1'(IMG_W) && ry < YW1'(IMG_H) && frame < F_W'(FRAMES);
    cx = s1_hf ? W_M1 - s1_x : s1_x;
    addr_c = ADDR_W'(32'(s1_f) * FSZ + 32'(s1_y) * WSZ + 32'(cx));
    opq = di[ROM_LAT-1] && (!KEY_EN || rom_dout != KEY_CLR);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_in <= 1'b0;
      s1_hf <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      s1_f <= '0;
      s2_v <= 1'b0;
      s2_in <= 1'b0;
      rom_addr <= '0;
      dv <= '0;
      di <= '0;
      out_valid <= 1'b0;
      clr <= '0;
      hit <= 1'b0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_in <= in_c;
        s1_hf <= hflip;
        s1_x <= rx[X_W-1:0];
        s1_y <= ry[Y_W-1:0];
        s1_f <= frame;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_in <= s1_in;
        rom_addr <= s1_in ? addr_c : '0;
      end
      dv <= ROM_LAT'({dv, s2_v});
      di <= ROM_LAT'({di, s2_in});
      out_valid <= dv[ROM_LAT-1];
      if (dv[ROM_LAT-1]) begin
        clr <= opq ? rom_dout : BG_CLR;
        hit <= opq;
      end
    end
  end
endmodule

// File: tb/tb_img_sprite_fetch.sv
// tb_img_sprite_fetch: randomized check of two img_sprite_fetch builds (default, and FRAMES=4/ROM_LAT=3).
module tb_img_sprite_fetch;
  localparam int N = 8192;
`ifdef IMG_KEY_EN
  localparam bit KEY = 1'b1;
`else
  localparam bit KEY = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, hflip = 1'b0;
  logic [9:0] x = '0, org_x = '0;
  logic [8:0] y = '0, org_y = '0;
  logic [2:0] frame = '0;
  logic [16:0] ra0, ra1;
  logic [11:0] dout0, dout1, cl0, cl1;
  logic ov0, ov1, ht0, ht1;
  logic [11:0] mem [0:44799];
  logic [11:0] q0;
  logic [11:0] q1 [3];
  int tests = 0, fails = 0;
  int n = 0, kill = 0;
  bit hv [2][N];
  bit hin [2][N];
  int hadr [2][N];
  int e_ra [2], e_ov [2], e_cl [2], e_ht [2];

  always #5 clk = ~clk;

  img_sprite_fetch u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .org_x(org_x), .org_y(org_y),
    .hflip(hflip), .frame(frame[0:0]), .rom_addr(ra0), .rom_dout(dout0), .out_valid(ov0), .clr(cl0), .hit(ht0));
  img_sprite_fetch #(.FRAMES(4), .ROM_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .org_x(org_x), .org_y(org_y),
    .hflip(hflip), .frame(frame), .rom_addr(ra1), .rom_dout(dout1), .out_valid(ov1), .clr(cl1), .hit(ht1));

  function automatic logic [11:0] rd(input logic [16:0] a);
    return a < 17'd44800 ? mem[a] : 12'h000;
  endfunction

  // ROM stubs with 1 and 3 cycles of read latency
  always @(posedge clk) begin
    q0 <= rd(ra0);
    q1[0] <= rd(ra1);
    q1[1] <= q1[0];
    q1[2] <= q1[1];
  end
  assign dout0 = q0;
  assign dout1 = q1[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void refm(input int flim, input int fr, output bit ins, output int a);
    int rx, ry, cx;
    rx = int'(x) - int'(org_x);
    ry = int'(y) - int'(org_y);
    ins = rx >= 0 && rx < 280 && ry >= 0 && ry < 40 && fr < flim;
    cx = hflip ? 279 - rx : rx;
    a = ins ? fr * 11200 + 280 * ry + cx : 0;
  endfunction

  function automatic bit vld(input int i, input int k);
    return k >= 0 && k > kill && hv[i][k];
  endfunction

  always @(posedge clk) begin
    bit ins, h;
    int a, k, lat, fr;
    logic [11:0] w;
    n++;
    for (int i = 0; i < 2; i++) begin
      fr = i == 0 ? int'(frame[0]) : int'(frame);
      refm(i == 0 ? 1 : 4, fr, ins, a);
      hv[i][n] = in_valid && rst_n;
      hin[i][n] = ins;
      hadr[i][n] = a;
    end
    if (!rst_n) begin
      kill = n;
      for (int i = 0; i < 2; i++) begin
        e_ra[i] = 0;
        e_ov[i] = 0;
        e_cl[i] = 0;
        e_ht[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        lat = i == 0 ? 1 : 3;
        if (vld(i, n - 1)) e_ra[i] = hadr[i][n-1];
        k = n - 2 - lat;
        e_ov[i] = int'(vld(i, k));
        if (e_ov[i] != 0) begin
          w = mem[hadr[i][k]];
          h = hin[i][k] && !(KEY && w == 12'hF0F);
          e_ht[i] = int'(h);
          e_cl[i] = h ? int'(w) : 0;
        end
      end
    end
    #1;
    chk("ra0", 32'(ra0), e_ra[0]);
    chk("ov0", 32'(ov0), e_ov[0]);
    chk("clr0", 32'(cl0), e_cl[0]);
    chk("hit0", 32'(ht0), e_ht[0]);
    chk("ra1", 32'(ra1), e_ra[1]);
    chk("ov1", 32'(ov1), e_ov[1]);
    chk("clr1", 32'(cl1), e_cl[1]);
    chk("hit1", 32'(ht1), e_ht[1]);
  end

  task automatic px(input int xx, input int yy, input int ox, input int oy, input int hf, input int fr);
    @(negedge clk);
    in_valid = 1'b1;
    x = 10'(xx);
    y = 9'(yy);
    org_x = 10'(ox);
    org_y = 9'(oy);
    hflip = hf[0];
    frame = 3'(fr);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // single pixel, then check the address it produces on both builds
  task automatic pa(input string tag, input int xx, input int yy, input int ox, input int oy,
                    input int hf, input int fr, input int a0, input int a1);
    px(xx, yy, ox, oy, hf, fr);
    idle(2);
    chk({tag, "_a0"}, 32'(ra0), a0);
    chk({tag, "_a1"}, 32'(ra1), a1);
  endtask

  task automatic rnd_px(input bit v);
    int ox, oy;
    ox = int'($urandom_range(0, 1023));
    oy = int'($urandom_range(0, 511));
    if ($urandom_range(0, 7) == 0)
      px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)), ox, oy, 0, 0);
    else
      px(ox + int'($urandom_range(0, 300)) - 10, oy + int'($urandom_range(0, 60)) - 10, ox, oy,
         int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    in_valid = v;
  endtask

  initial begin
    int l0, l1;
    for (int a = 0; a < 44800; a++) mem[a] = 12'($urandom);
    mem[565] = 12'hF0F;
    repeat (6) begin
      @(negedge clk);
      in_valid = ~in_valid;
      x = 10'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    px(5, 2, 0, 0, 0, 0);
    l0 = 0;
    l1 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 2) begin
        chk("a565_0", 32'(ra0), 565);
        chk("a565_1", 32'(ra1), 565);
      end
      if (ov0 && l0 == 0) l0 = c;
      if (ov1 && l1 == 0) l1 = c;
    end
    chk("lat0", l0, 4);
    chk("lat1", l1, 6);
    pa("max", 279, 39, 0, 0, 0, 0, 11199, 11199);
    pa("lft", 99, 50, 100, 50, 0, 0, 0, 0);
    pa("rgt", 380, 50, 100, 50, 0, 0, 0, 0);
    pa("bot", 100, 90, 100, 50, 0, 0, 0, 0);
    pa("org", 0, 0, 100, 50, 0, 0, 0, 0);
    pa("tl", 100, 50, 100, 50, 0, 0, 0, 0);
    pa("br", 379, 89, 100, 50, 0, 0, 11199, 11199);
    pa("flp", 0, 1, 0, 0, 1, 2, 559, 22959);
    pa("f4", 0, 1, 0, 0, 1, 4, 559, 0);
    pa("f3", 0, 1, 0, 0, 1, 3, 0, 34159);
    idle(8);
    for (int b = 0; b < 640; b++) begin
      if (b == 300) begin
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
      end
      rnd_px(1'b1);
    end
    idle(10);
    for (int b = 0; b < 1500; b++) rnd_px($urandom_range(0, 3) != 0);
    idle(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
